// File: rtl/sprite_pkg.sv
// sprite_pkg: shared widths, colour type and the fixed 32-entry palette used
// by the sprite fetch pipeline. Palette entry 0 is the transparent colour and
// is kept black so a gated-off index produces RGB = 0 directly.
`timescale 1ns/1ps
package sprite_pkg;

    localparam int IDX_W  = 5;
    localparam int ADDR_W = 19;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t PALETTE [0:31] = '{
        24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
        24'h0000FF, 24'hFFFF00, 24'hFF00FF, 24'h00FFFF,
        24'h808080, 24'hC0C0C0, 24'h800000, 24'h008000,
        24'h000080, 24'h808000, 24'h800080, 24'h008080,
        24'hFF8000, 24'h80FF00, 24'h00FF80, 24'h0080FF,
        24'h8000FF, 24'hFF0080, 24'h402010, 24'h102040,
        24'h204010, 24'hF0E0D0, 24'hD0E0F0, 24'hE0F0D0,
        24'h123456, 24'h654321, 24'hABCDEF, 24'hFEDCBA
    };

    // Index 0 is the transparent key; every other index draws.
    function automatic logic is_opaque(input logic [IDX_W-1:0] idx);
        return (idx != {IDX_W{1'b0}});
    endfunction

endpackage

// File: rtl/sprite_palette.sv
// sprite_palette: one registered lookup stage turning a palette index into
// 24-bit colour plus an opaque flag.
`timescale 1ns/1ps
module sprite_palette
    import sprite_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx,
    output rgb_t             rgb,
    output logic             opaque
);

    // Register the colour and opacity of the incoming index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb    <= 24'h000000;
            opaque <= 1'b0;
        end else begin
            rgb    <= PALETTE[idx];
            opaque <= is_opaque(idx);
        end
    end

endmodule

// File: rtl/sprite_fetch.sv
// sprite_fetch: computes the frame-RAM read address for each display pixel
// inside the current animation frame of a sprite sheet, then turns the
// returned palette index into RGB with a hit flag, three cycles after the
// pixel is presented. Owns the animation frame counter (advanced on
// frame_start). Optional build macro SPRITE_MIRROR_EN adds the mirror_x
// input for horizontal flipping.
`timescale 1ns/1ps
module sprite_fetch
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 60,
    parameter int SPR_H      = 60,
    parameter int NUM_FRAMES = 20,
    parameter int FRAME_DIV  = 6
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic [9:0]        SpriteX,
    input  logic [9:0]        SpriteY,
    input  logic              anim_en,
`ifdef SPRITE_MIRROR_EN
    input  logic              mirror_x,
`endif
    input  logic              pix_valid,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] read_address,
    input  logic [IDX_W-1:0]  data_Out,
    output logic              out_valid,
    output logic              out_hit,
    output logic [7:0]        R,
    output logic [7:0]        G,
    output logic [7:0]        B
);

    localparam int FRAME_SIZE = SPR_W * SPR_H;
    localparam int DIV_W      = (FRAME_DIV  > 1) ? $clog2(FRAME_DIV)  : 1;
    localparam int FIDX_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    // Latched sprite placement
    logic [9:0]        sx_r;
    logic [9:0]        sy_r;
    logic              armed_r;
    logic              mirror_s;

    // Animation state
    logic [DIV_W-1:0]  div_cnt_r;
    logic [FIDX_W-1:0] frame_idx_r;
    logic [ADDR_W-1:0] frame_base_r;

    // Stage 0 combinational results
    logic [10:0]       dx_s;
    logic [10:0]       dy_s;
    logic              in_box_s;
    logic [ADDR_W-1:0] col_s;
    logic [ADDR_W-1:0] addr_s;

    // Delay alignment with the RAM and palette latency
    logic              s1_valid_r;
    logic              s1_hit_r;
    logic              s2_valid_r;
    logic              s2_hit_r;

    logic [IDX_W-1:0]  pal_idx_s;
    rgb_t              pal_rgb_s;
    logic              pal_opaque_s;

    // Capture the sprite position at vertical blank and arm hit detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx_r    <= 10'd0;
            sy_r    <= 10'd0;
            armed_r <= 1'b0;
        end else if (frame_start) begin
            sx_r    <= SpriteX;
            sy_r    <= SpriteY;
            armed_r <= 1'b1;
        end
    end

`ifdef SPRITE_MIRROR_EN
    logic mirror_r;

    // Capture the horizontal flip select together with the position.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mirror_r <= 1'b0;
        end else if (frame_start) begin
            mirror_r <= mirror_x;
        end
    end

    assign mirror_s = mirror_r;
`else
    assign mirror_s = 1'b0;
`endif

    // Step the animation: divide frame_start pulses, then walk frame_base
    // through the sheet one frame-size at a time, wrapping after the last.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt_r    <= '0;
            frame_idx_r  <= '0;
            frame_base_r <= '0;
        end else if (frame_start && anim_en) begin
            if (div_cnt_r == DIV_W'(FRAME_DIV - 1)) begin
                div_cnt_r <= '0;
                if (frame_idx_r == FIDX_W'(NUM_FRAMES - 1)) begin
                    frame_idx_r  <= '0;
                    frame_base_r <= '0;
                end else begin
                    frame_idx_r  <= frame_idx_r + FIDX_W'(1);
                    frame_base_r <= frame_base_r + ADDR_W'(FRAME_SIZE);
                end
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
        end
    end

    // Stage 0: signed offsets into the sprite box and the RAM address.
    // Offsets are 11 bits so a pixel left of / above the sprite goes negative.
    always_comb begin
        dx_s     = {1'b0, DrawX} - {1'b0, sx_r};
        dy_s     = {1'b0, DrawY} - {1'b0, sy_r};
        in_box_s = 1'b0;
        col_s    = ADDR_W'(dx_s[9:0]);
        addr_s   = frame_base_r;

        if (pix_valid && armed_r && !dx_s[10] && !dy_s[10] &&
            (dx_s < 11'(SPR_W)) && (dy_s < 11'(SPR_H))) begin
            in_box_s = 1'b1;
        end else begin
            in_box_s = 1'b0;
        end

        if (mirror_s) begin
            col_s = ADDR_W'(SPR_W - 1) - ADDR_W'(dx_s[9:0]);
        end else begin
            col_s = ADDR_W'(dx_s[9:0]);
        end

        if (in_box_s) begin
            addr_s = frame_base_r + ADDR_W'(dy_s[9:0]) * ADDR_W'(SPR_W) + col_s;
        end else begin
            addr_s = frame_base_r;
        end
    end

    // Pipeline registers: address out to the RAM, valid/hit carried
    // alongside so they meet the RAM data and palette output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address <= '0;
            s1_valid_r   <= 1'b0;
            s1_hit_r     <= 1'b0;
            s2_valid_r   <= 1'b0;
            s2_hit_r     <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            read_address <= addr_s;
            s1_valid_r   <= pix_valid;
            s1_hit_r     <= in_box_s;
            s2_valid_r   <= s1_valid_r;
            s2_hit_r     <= s1_hit_r;
            out_valid    <= s2_valid_r;
        end
    end

    // Force the transparent index for out-of-box pixels so the palette
    // stage yields both hit=0 and black without a separate mask register.
    always_comb begin
        pal_idx_s = {IDX_W{1'b0}};
        if (s2_hit_r) begin
            pal_idx_s = data_Out;
        end else begin
            pal_idx_s = {IDX_W{1'b0}};
        end
    end

    sprite_palette u_palette (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .idx    (pal_idx_s),
        .rgb    (pal_rgb_s),
        .opaque (pal_opaque_s)
    );

    assign out_hit = pal_opaque_s;
    assign R       = pal_rgb_s.r;
    assign G       = pal_rgb_s.g;
    assign B       = pal_rgb_s.b;

endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: directed and randomized checks of sprite_fetch against a
// behavioural model (pulse count -> frame, plain coordinate arithmetic).
`timescale 1ns/1ps
module tb_sprite_fetch;

    localparam int SPR_W      = 60;
    localparam int SPR_H      = 60;
    localparam int NUM_FRAMES = 20;
    localparam int FRAME_DIV  = 6;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  SpriteX = 10'd0;
    logic [9:0]  SpriteY = 10'd0;
    logic        anim_en = 1'b0;
`ifdef SPRITE_MIRROR_EN
    logic        mirror_x = 1'b0;
`endif
    logic        pix_valid = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [18:0] read_address;
    logic [4:0]  data_Out = 5'd0;
    logic        out_valid;
    logic        out_hit;
    logic [7:0]  R, G, B;

    sprite_fetch #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NUM_FRAMES), .FRAME_DIV(FRAME_DIV)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .SpriteX(SpriteX), .SpriteY(SpriteY), .anim_en(anim_en),
`ifdef SPRITE_MIRROR_EN
        .mirror_x(mirror_x),
`endif
        .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .read_address(read_address), .data_Out(data_Out),
        .out_valid(out_valid), .out_hit(out_hit), .R(R), .G(G), .B(B)
    );

    initial forever #5 Clk = ~Clk;

    typedef struct {
        bit          valid;
        bit          hit;
        int          addr;
        logic [23:0] rgb;
    } exp_t;

    // Expected colours, written out independently of the design package.
    logic [23:0] pal [32] = '{
        24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
        24'h0000FF, 24'hFFFF00, 24'hFF00FF, 24'h00FFFF,
        24'h808080, 24'hC0C0C0, 24'h800000, 24'h008000,
        24'h000080, 24'h808000, 24'h800080, 24'h008080,
        24'hFF8000, 24'h80FF00, 24'h00FF80, 24'h0080FF,
        24'h8000FF, 24'hFF0080, 24'h402010, 24'h102040,
        24'h204010, 24'hF0E0D0, 24'hD0E0F0, 24'hE0F0D0,
        24'h123456, 24'h654321, 24'hABCDEF, 24'hFEDCBA
    };

    logic [4:0] ram_ovr [int];
    exp_t       exp_q [$];
    int         tests = 0;
    int         fails = 0;
    int         m_sx = 0, m_sy = 0, m_pulses = 0, last_addr = 0;
    bit         m_armed = 1'b0, m_mirror = 1'b0;

    // Frame RAM contents: directed overrides, otherwise a fixed scramble.
    function automatic logic [4:0] mem_fn(input int a);
        if (ram_ovr.exists(a)) return ram_ovr[a];
        return 5'((a * 37 + (a >> 3)) % 32);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_idle();
        exp_t e;
        e.valid = 1'b0; e.hit = 1'b0; e.addr = 0; e.rgb = 24'h0;
        exp_q.push_back(e);
    endtask

    // Assert reset mid-cycle, check outputs clear at once, release after an edge.
    task automatic do_reset();
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        Reset_n     = 1'b0;
        #2;
        chk("rst_addr",  32'(read_address), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_hit",   32'(out_hit), 32'd0);
        chk("rst_rgb",   32'({R, G, B}), 32'd0);
        @(posedge Clk); #1;
        Reset_n  = 1'b1;
        m_armed  = 1'b0; m_sx = 0; m_sy = 0; m_pulses = 0; m_mirror = 1'b0;
        last_addr = 0;
        exp_q.delete();
        push_idle();
        push_idle();
    endtask

    // Present one pixel for one cycle, predict its results, check the pipe.
    task automatic step(input logic pv, input logic [9:0] x, input logic [9:0] y, input logic fs);
        exp_t e;
        exp_t o;
        int   dx, dy, col, fr;
        logic [4:0] idx;
        pix_valid = pv; DrawX = x; DrawY = y; frame_start = fs;
        dx  = int'(x) - m_sx;
        dy  = int'(y) - m_sy;
        fr  = (m_pulses / FRAME_DIV) % NUM_FRAMES;
        col = m_mirror ? (SPR_W - 1 - dx) : dx;
        e.valid = pv;
        e.addr  = fr * SPR_W * SPR_H;
        if (pv && m_armed && dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H) begin
            e.addr = e.addr + dy * SPR_W + col;
            idx    = mem_fn(e.addr);
            e.hit  = (idx != 5'd0);
        end else begin
            idx   = 5'd0;
            e.hit = 1'b0;
        end
        e.rgb = e.hit ? pal[idx] : 24'h0;
        exp_q.push_back(e);
        if (fs) begin
            m_armed = 1'b1;
            m_sx = int'(SpriteX);
            m_sy = int'(SpriteY);
`ifdef SPRITE_MIRROR_EN
            m_mirror = mirror_x;
`endif
            if (anim_en) m_pulses++;
        end
        @(posedge Clk); #1;
        frame_start = 1'b0;
        data_Out  = mem_fn(last_addr);
        last_addr = int'(read_address);
        chk("read_address", 32'(read_address), 32'(exp_q[exp_q.size() - 1].addr));
        o = exp_q.pop_front();
        chk("out_valid", 32'(out_valid), 32'(o.valid));
        chk("out_hit",   32'(out_hit), 32'(o.hit));
        chk("out_rgb",   32'({R, G, B}), 32'(o.rgb));
    endtask

    initial begin
        #1;
        do_reset();

        // Pixel before any frame_start: valid but never a hit.
        step(1'b1, 10'd0, 10'd0, 1'b0);
        step(1'b0, 10'd0, 10'd0, 1'b0);
        step(1'b0, 10'd0, 10'd0, 1'b0);
        chk("unarmed_valid", 32'(out_valid), 32'd1);
        chk("unarmed_hit",   32'(out_hit), 32'd0);

        // Place the sprite and probe inside, on the left edge and right edge.
        ram_ovr[125] = 5'd3;
        ram_ovr[1]   = 5'd0;
        SpriteX = 10'd100; SpriteY = 10'd50; anim_en = 1'b0;
        step(1'b0, 10'd0, 10'd0, 1'b1);
        step(1'b1, 10'd105, 10'd52, 1'b0);
        chk("addr_125", 32'(read_address), 32'd125);
        step(1'b1, 10'd101, 10'd50, 1'b0);
        step(1'b1, 10'd99, 10'd50, 1'b0);
        chk("hit_pal3", 32'(out_hit), 32'd1);
        chk("rgb_pal3", 32'({R, G, B}), 32'(pal[3]));
        chk("miss_left_addr", 32'(read_address), 32'd0);
        step(1'b1, 10'd160, 10'd50, 1'b0);
        chk("miss_right_addr", 32'(read_address), 32'd0);
        step(1'b0, 10'd0, 10'd0, 1'b0);
        chk("idx0_hit", 32'(out_hit), 32'd0);
        step(1'b0, 10'd0, 10'd0, 1'b0);

        // Animation: 6 pulses advance one frame, disabled pulses hold, 120 wrap.
        anim_en = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 10'd0, 10'd0, 1'b1);
        step(1'b0, 10'd0, 10'd0, 1'b0);
        chk("base_3600", 32'(read_address), 32'd3600);
        anim_en = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 10'd0, 10'd0, 1'b1);
        step(1'b0, 10'd0, 10'd0, 1'b0);
        chk("base_hold", 32'(read_address), 32'd3600);
        anim_en = 1'b1;
        for (int i = 0; i < 114; i++) step(1'b0, 10'd0, 10'd0, 1'b1);
        step(1'b0, 10'd0, 10'd0, 1'b0);
        chk("base_wrap", 32'(read_address), 32'd0);
        anim_en = 1'b0;

        // Back-to-back pixels across a frame_start that moves the sprite.
        step(1'b1, 10'd110, 10'd55, 1'b0);
        SpriteX = 10'd200; SpriteY = 10'd100;
        step(1'b1, 10'd110, 10'd55, 1'b1);
        step(1'b1, 10'd210, 10'd105, 1'b0);
        step(1'b1, 10'd110, 10'd55, 1'b0);
        chk("moved_old_miss", 32'(read_address), 32'd0);

`ifdef SPRITE_MIRROR_EN
        mirror_x = 1'b1; SpriteX = 10'd0; SpriteY = 10'd0;
        step(1'b0, 10'd0, 10'd0, 1'b1);
        step(1'b1, 10'd0, 10'd0, 1'b0);
        chk("mirror_59", 32'(read_address), 32'd59);
        mirror_x = 1'b0;
`endif

        // Randomized traffic with occasional moves/animation and one mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            bit fs;
            int tx, ty;
            if (i == 300) do_reset();
            fs = ($urandom_range(0, 24) == 0);
            if (fs) begin
                SpriteX = 10'($urandom_range(0, 1000));
                SpriteY = 10'($urandom_range(0, 1000));
                anim_en = 1'($urandom_range(0, 1));
`ifdef SPRITE_MIRROR_EN
                mirror_x = 1'($urandom_range(0, 1));
`endif
            end
            tx = m_sx + int'($urandom_range(0, 69)) - 5;
            ty = m_sy + int'($urandom_range(0, 69)) - 5;
            if (tx < 0) tx = 0;
            if (tx > 1023) tx = 1023;
            if (ty < 0) ty = 0;
            if (ty > 1023) ty = 1023;
            step(1'($urandom_range(0, 3) != 0), 10'(tx), 10'(ty), fs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_fetch.md
# sprite_fetch

Pixel-pipeline stage directly downstream of the sprite frame RAM. For each `DrawX`/`DrawY` from the VGA controller it computes the RAM `read_address` inside the current animation frame of a sprite sheet. It then takes the 5-bit palette index returned one cycle later and converts it to 24-bit RGB with a hit/transparency flag. It also owns the animation frame counter, which advances on vertical-blank pulses.

## Interface
- `SPR_W`, 60: sprite width in pixels.
- `SPR_H`, 60: sprite height in pixels.
- `NUM_FRAMES`, 20: animation frames stored back-to-back in the RAM (`SPR_W*SPR_H*NUM_FRAMES` ≤ 2^19).
- `FRAME_DIV`, 6: `frame_start` pulses per animation step; must be ≥ 1.
- `Clk` in 1: single clock, all logic on rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse at start of vertical blank.
- `SpriteX`, `SpriteY` in 10 each: sprite top-left corner; sampled only on `frame_start`.
- `anim_en` in 1: when 1, animation advances; when 0, the current frame is held.
- `pix_valid` in 1: `DrawX`/`DrawY` lie in the active display.
- `DrawX`, `DrawY` in 10 each: current pixel coordinate.
- `read_address` out 19: to frame RAM read port.
- `data_Out` in 5: palette index from the frame RAM, valid one cycle after `read_address`.
- `out_valid` out 1: R/G/B correspond to a pixel presented 3 cycles earlier.
- `out_hit` out 1: the pixel is inside the sprite box and its index is non-zero.
- `R`, `G`, `B` out 8 each: colour; 0 when `out_hit` = 0.

## Operation
- Position latch: on `frame_start`, register `SpriteX`/`SpriteY` and set `armed`=1. While `armed`=0 (after reset, before the first `frame_start`), every pixel is a miss.
- Box test, stage 0: signed 11-bit `dx = DrawX - sx`, `dy = DrawY - sy`. The pixel is `in_box` when `pix_valid && armed && 0 ≤ dx < SPR_W && 0 ≤ dy < SPR_H`.
- Address: `read_address = frame_base + dy*SPR_W + dx`, computed at 19 bits with no truncation for legal parameters. On a miss, `read_address = frame_base`.
- Animation counters:
  - `div_cnt` runs 0..FRAME_DIV-1.
  - `frame_idx` runs 0..NUM_FRAMES-1.
  - `frame_base` is `frame_idx*SPR_W*SPR_H`, maintained incrementally with no multiplier.
- On `frame_start` with `anim_en`=1:
  - If `div_cnt` = FRAME_DIV-1: `div_cnt` goes to 0, `frame_idx` advances, and `frame_base += SPR_W*SPR_H`. Both wrap to 0 after the last frame.
  - Otherwise `div_cnt` increments.
- With `anim_en`=0, all counters hold.
- Palette: registered 32-entry lookup. Index 0 is transparent, so `out_hit`=0 and RGB=0.

## Timing
- Pixel at cycle t:
  - `read_address` and the stage-1 `in_box`/`valid` registers at t+1.
  - `data_Out` at t+2.
  - `R`/`G`/`B`, `out_hit`, `out_valid` registered at t+3.
- Throughput is one pixel per cycle with no stalls.
- `out_valid` is `pix_valid` delayed by 3 cycles. `out_hit` is `in_box` delayed by 3 cycles AND (index ≠ 0).
- Pixels in flight keep the position and frame_base that were sampled at their own stage 0.
- `frame_start` coincident with `pix_valid`: that pixel uses the old position and frame. New values take effect from t+1.
- Reset (asynchronous, any time, including mid-line): the following all go to 0:
  - all pipeline valids
  - `out_hit`, `out_valid`, R, G, B
  - `read_address`
  - `div_cnt`, `frame_idx`, `frame_base`
  - latched position and `armed`
- After reset, in-flight pixels are discarded.

## Configuration
- `SPRITE_MIRROR_EN` defined: adds input `mirror_x` (1 bit), sampled on `frame_start`. When it is 1, the column offset is `SPR_W-1-dx`.
- `SPRITE_MIRROR_EN` undefined: the port is absent and the column offset is `dx`.

## Structure
- Package `sprite_pkg` holds:
  - `IDX_W`=5 and `ADDR_W`=19.
  - `typedef rgb_t` (8-bit r, g, b).
  - The 32-entry constant `PALETTE` array of `rgb_t`.
- Sub-module `sprite_palette`: one registered stage, index in, `rgb_t` and opaque flag out.
- Top-level `sprite_fetch` holds the latch, the counters, the box test, the address, and delay alignment.

## Test plan
- Reset, then `pix_valid` at (0,0) before any `frame_start` -> `out_valid`=1 at t+3, `out_hit`=0, RGB=0.
- `frame_start` with Sprite=(100,50), then pixel (105,52) -> `read_address`=125 at t+1. Model RAM returns 3 -> `out_hit`=1 with `PALETTE[3]` at t+3.
- Pixel (99,50) and pixel (160,50) -> miss, `read_address`=`frame_base`. RAM index 0 inside the box -> `out_hit`=0.
- `anim_en`=1 for 6 `frame_start` pulses -> `frame_base`=3600. After 120 pulses -> wraps to 0. With `anim_en`=0 -> no change.
- Back-to-back pixels across a `frame_start` that moves the sprite -> earlier pixels use the old position and later ones the new. Assert `Reset_n` mid-stream -> all outputs 0 immediately.
- `SPRITE_MIRROR_EN` build: `mirror_x`=1, Sprite=(0,0), pixel (0,0) -> `read_address`=59.
